seq_div: RTL and testbench

- Multi-cycle restoring divider for the ALU datapath: unsigned integer division, one quotient bit per clock.
- Built on the same trial-subtract arithmetic that the adder/carry-look-ahead blocks provide.
- Complements the adders: they combine operands combinationally, this block takes the quotient and remainder apart over WIDTH cycles under a start/done handshake.

---
 rtl/seq_div.sv | 126 ++++++++++++
 tb/tb_seq_div.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Multi-cycle restoring divider: one quotient bit per clock under a start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (sign handled around the unsigned core).
module seq_div #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] dvd_sr;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q_sr;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    // The partial remainder is always below the divisor after a step, so its top bit
    // is never needed between iterations and P is kept WIDTH bits wide.
    always_comb begin
        p_shift = {1'b0, p, dvd_sr[WIDTH-1]};
        trial   = p_shift - {1'b0, dvs};
        p_next  = trial[WIDTH] ? p_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next  = {q_sr[WIDTH-2:0], ~trial[WIDTH]};
    end

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
    assign q_res   = neg_q ? -q_next : q_next;
    assign r_res   = neg_r ? -p_next : p_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == StIdle && start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_res   = q_next;
    assign r_res   = p_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            dvd_sr      <= '0;
            dvs         <= '0;
            p           <= '0;
            q_sr        <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= StDone;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state  <= StRun;
                            busy   <= 1'b1;
                            dvd_sr <= dvd_mag;
                            dvs    <= dvs_mag;
                            p      <= '0;
                            q_sr   <= '0;
                            count  <= '0;
                        end
                    end
                end
                StRun: begin
                    p      <= p_next;
                    dvd_sr <= {dvd_sr[WIDTH-2:0], 1'b0};
                    q_sr   <= q_next;
                    count  <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state       <= StDone;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_res;
                        remainder   <= r_res;
                        div_by_zero <= 1'b0;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus randomized operands against a
// plain-arithmetic reference model.
module tb_seq_div;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_div #(.WIDTH(W), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
`ifdef SEQ_DIV_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            dz = 1'b0;
        end
    endfunction

    // Issues one request and waits (bounded) for done; lat counts cycles from start to done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        q = quotient; r = remainder; dz = div_by_zero;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] a [$];
        logic [W-1:0] b [$];
        logic [W-1:0] eq [$];
        logic [W-1:0] er [$];
        logic [W-1:0] q, r;
        logic dz, edz;
        int lat, bcnt;
`ifdef SEQ_DIV_SIGNED_EN
        a = '{8'h9C, 8'h80}; b = '{8'd7, 8'hFF}; eq = '{8'hF2, 8'h80}; er = '{8'hFE, 8'h00};
`else
        a = '{8'd200, 8'd13, 8'd5, 8'd255, 8'd255};
        b = '{8'd7, 8'd0, 8'd9, 8'd1, 8'd255};
        eq = '{8'd28, 8'hFF, 8'd0, 8'd255, 8'd1};
        er = '{8'd4, 8'd13, 8'd5, 8'd0, 8'd0};
`endif
        foreach (a[i]) begin
            edz = (b[i] == '0);
            run_op(a[i], b[i], q, r, dz, lat, bcnt);
            checks++;
            if (q !== eq[i] || r !== er[i] || dz !== edz) begin
                errors++;
                $display("FAIL directed_%0d: %h/%h got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, a[i], b[i], q, r, dz, eq[i], er[i], edz);
            end
            checks++;
            if (lat !== (edz ? 1 : W + 1) || bcnt !== (edz ? 0 : W)) begin
                errors++;
                $display("FAIL directed_latency_%0d: got lat=%0d busy=%0d, want lat=%0d busy=%0d",
                         i, lat, bcnt, edz ? 1 : W + 1, edz ? 0 : W);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_%0d: done=%b one cycle after done, want 0", i, done);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] q, r;
        logic dz;
        int lat, bcnt;
        run_op(8'd255, 8'd255, q, r, dz, lat, bcnt);
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd3;
        @(negedge clk);
        dividend = 8'd9; divisor = 8'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = W'($urandom); divisor = W'($urandom);
        checks++;
        if (quotient !== 8'd1 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL hold_during_run: got q=%h r=%h, want q=01 r=00", quotient, remainder);
        end
        lat = 3;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== W + 1 || quotient !== 8'd33 || remainder !== 8'd1 || div_by_zero !== 1'b0)
        begin
            errors++;
            $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d dz=%b, want lat=%0d q=33 r=1 dz=0",
                     lat, quotient, remainder, div_by_zero, W + 1);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || quotient !== 8'd33 || remainder !== 8'd1) begin
            errors++;
            $display("FAIL hold_after_done: got busy=%b q=%0d r=%0d, want busy=0 q=33 r=1",
                     busy, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] q, r;
        logic dz;
        logic saw_done;
        int lat, bcnt;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL aborted_op: got done/busy activity=%b after reset, want 0", saw_done);
        end
        run_op(8'd50, 8'd5, q, r, dz, lat, bcnt);
        checks++;
        if (q !== 8'd10 || r !== 8'd0 || dz !== 1'b0 || lat !== W + 1) begin
            errors++;
            $display("FAIL after_reset_op: got q=%0d r=%0d dz=%b lat=%0d, want q=10 r=0 dz=0 lat=%0d",
                     q, r, dz, lat, W + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic dz, edz;
        int lat, bcnt;
        for (int i = 0; i < 80; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if (i % 10 == 3) b = 8'd1;
            model(a, b, eq, er, edz);
            run_op(a, b, q, r, dz, lat, bcnt);
            checks++;
            if (q !== eq || r !== er || dz !== edz || lat !== (edz ? 1 : W + 1)) begin
                errors++;
                $display("FAIL random_%0d: %h/%h got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                         i, a, b, q, r, dz, lat, eq, er, edz, edz ? 1 : W + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
